uart_tx_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares a single UART transmit line between up to NREQ byte-level requesters. It accepts one byte at a time over a per-requester req/grant handshake and serializes it on `u_tx`. The frame is one start bit (0), 8 data bits LSB first, one parity bit equal to XOR of the data, and one stop bit (1). This is the format the team's UART receiver (`uart_slave`) decodes. The block sits between bus-side producers and the serial link.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between NREQ byte requesters.
// Frame: start(0), 8 data bits LSB first, even parity (XOR of data), stop(1).
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              tx_done,
  output logic              u_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic            busy_q, busy_d;
  logic            tx_done_q, tx_done_d;
  logic            u_tx_q, u_tx_d;

  logic            win_found;
  logic [2:0]      win_id;
  logic [7:0]      win_data;
  logic            bit_end;
  int              j;

  // Search upward from ptr with wrap; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_id    = 3'(j);
        win_data  = req_data[8*j +: 8];
      end
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_d      = par_q;
    ptr_d      = ptr_q;
    grant_d    = '0;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    u_tx_d     = u_tx_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en && win_found) begin
          grant_d    = ONE_HOT0 << win_id;
          grant_id_d = win_id;
          data_d     = win_data;
          par_d      = ^win_data;
          ptr_d      = (win_id == 3'(NREQ - 1)) ? 3'd0 : win_id + 3'd1;
          state_d    = S_START;
          u_tx_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          u_tx_d  = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
            u_tx_d  = par_q;
          end else begin
            idx_d  = idx_q + 3'd1;
            u_tx_d = data_q[idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          u_tx_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        u_tx_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      u_tx_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_q      <= par_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      u_tx_q     <= u_tx_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign u_tx     = u_tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a CLKS_PER_BIT=4 instance for arbitration and
// framing, plus a CLKS_PER_BIT=1 instance for the cycle-exact parity-one frame.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic [2:0]  grant_id;
  logic        busy, tx_done, u_tx;

  logic        en1 = 1'b1;
  logic [3:0]  req1 = '0;
  logic [31:0] req_data1 = '0;
  logic [3:0]  grant1;
  logic [2:0]  grant_id1;
  logic        busy1, tx_done1, u_tx1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(.NREQ(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .grant(grant), .grant_id(grant_id), .busy(busy), .tx_done(tx_done), .u_tx(u_tx)
  );

  uart_tx_arbiter #(.NREQ(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .req(req1), .req_data(req_data1),
    .grant(grant1), .grant_id(grant_id1), .busy(busy1), .tx_done(tx_done1), .u_tx(u_tx1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output bit ok, output int lows);
    ok   = 1'b0;
    lows = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (grant != 4'b0) begin
        ok = 1'b1;
        break;
      end
      if (!busy) lows++;
    end
  endtask

  task automatic wait_idle(input int limit);
    bit idle_seen;
    idle_seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(idle_seen), 32'd1);
  endtask

  logic [10:0] fr;
  bit          ok, seen;
  int          lows, t_prev, n;
  logic [2:0]  exp_seq [4];

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_u_tx", 32'(u_tx), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);

    // single byte A5 on requester 2, 4 clocks per bit
    rst = 1'b0;
    req = 4'b0100;
    req_data[23:16] = 8'hA5;
    tick();
    check("a5_grant", 32'(grant), 32'h4);
    check("a5_grant_id", 32'(grant_id), 32'd2);
    check("a5_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    req_data[23:16] = 8'h3C;
    tick();
    check("a5_grant_pulse", 32'(grant), 32'd0);
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
    for (int k = 0; k < 11; k++) begin
      check($sformatf("a5_bit%0d", k), 32'(u_tx), 32'(fr[k]));
      if (k < 10) repeat (4) tick();
    end
    repeat (2) tick();
    check("a5_done_early", 32'(tx_done), 32'd0);
    tick();
    check("a5_done_44", 32'(tx_done), 32'd1);
    check("a5_busy_end", 32'(busy), 32'd0);
    tick();
    check("a5_done_pulse", 32'(tx_done), 32'd0);

    // parity-one byte 07, one clock per bit
    req1 = 4'b0001;
    req_data1[7:0] = 8'h07;
    tick();
    check("p1_grant", 32'(grant1), 32'h1);
    req1 = 4'b0000;
    fr = {1'b1, 1'b1, 8'h07, 1'b0};
    for (int k = 0; k < 11; k++) begin
      check($sformatf("p1_bit%0d", k), 32'(u_tx1), 32'(fr[k]));
      check($sformatf("p1_nodone%0d", k), 32'(tx_done1), 32'd0);
      tick();
    end
    check("p1_done_11", 32'(tx_done1), 32'd1);

    // simultaneous requests after reset: 0,1,2,3 spaced 45 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      wait_grant(200, ok, lows);
      check($sformatf("rr_seen%0d", g), 32'(ok), 32'd1);
      check($sformatf("rr_id%0d", g), 32'(grant_id), 32'(g));
      if (g > 0) begin
        check($sformatf("rr_gap%0d", g), 32'(cyc - t_prev), 32'd45);
        check($sformatf("rr_lowbusy%0d", g), 32'(lows), 32'd1);
      end
      t_prev = cyc;
      req[g] = 1'b0;
    end

    // fairness: req 0 and 3 held
    req = 4'b1001;
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd3; exp_seq[2] = 3'd0; exp_seq[3] = 3'd3;
    for (int g = 0; g < 4; g++) begin
      wait_grant(200, ok, lows);
      check($sformatf("fair_seen%0d", g), 32'(ok), 32'd1);
      check($sformatf("fair_id%0d", g), 32'(grant_id), 32'(exp_seq[g]));
    end
    req = 4'b0000;
    wait_idle(100);

    // enable gating
    en  = 1'b0;
    req = 4'b0010;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (grant != 4'b0) seen = 1'b1;
    end
    check("en0_no_grant", 32'(seen), 32'd0);
    en = 1'b1;
    tick();
    check("en1_grant", 32'(grant), 32'h2);
    repeat (10) tick();
    en = 1'b0;
    n = 10;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("en_mid_done", 32'(seen), 32'd1);
    check("en_mid_len", 32'(n), 32'd44);
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (grant != 4'b0) seen = 1'b1;
    end
    check("en_mid_no_regrant", 32'(seen), 32'd0);
    req = 4'b0000;
    en  = 1'b1;

    // reset during data bit 3; ptr is 2 so requester 1 wins via wrap
    req = 4'b0010;
    req_data[15:8] = 8'h00;
    tick();
    check("rm_grant_id", 32'(grant_id), 32'd1);
    req = 4'b0000;
    repeat (17) tick();
    check("rm_bit3_low", 32'(u_tx), 32'd0);
    check("rm_busy_pre", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rm_async_u_tx", 32'(u_tx), 32'd1);
    check("rm_async_busy", 32'(busy), 32'd0);
    check("rm_grant_id_clr", 32'(grant_id), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      tick();
      if (tx_done || busy) seen = 1'b1;
    end
    check("rm_no_done", 32'(seen), 32'd0);

    // request held across reset release
    rst = 1'b1;
    req = 4'b0100;
    tick();
    rst = 1'b0;
    tick();
    check("rm_after_grant", 32'(grant), 32'h4);
    check("rm_after_id", 32'(grant_id), 32'd2);
    req = 4'b0000;
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
